// File: rtl/my_pkg.sv
// Shared pipeline types: data/address widths and the ID/EX pipeline word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package my_pkg;

  localparam int WD         = 32;  // data word width
  localparam int SEL        = 5;   // register address width
  localparam int PCNT_W_DEF = 16;  // default load-use stall counter width

  // Contents of the ID/EX pipeline register (valid bit kept separately).
  typedef struct packed {
    logic [WD-1:0]  op1;
    logic [WD-1:0]  op2;
    logic [WD-1:0]  imm;
    logic [SEL-1:0] rd;
    logic           we;
    logic           is_load;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_operand_bypass.sv
// Operand select: zero register, same-cycle write-back bypass, else register file data.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
//   rs_i      : source register address
//   rf_rd_i   : asynchronous register file read data for rs_i
//   wb_*_i    : write-back port seen by the register file this cycle
//   op_o      : selected operand
module operand_bypass
  import my_pkg::*;
#(
  parameter int WD       = my_pkg::WD,
  parameter int SEL      = my_pkg::SEL,
  parameter int ZERO_REG = 1
) (
  input  logic [SEL-1:0] rs_i,
  input  logic [WD-1:0]  rf_rd_i,
  input  logic           wb_we_i,
  input  logic [SEL-1:0] wb_rd_i,
  input  logic [WD-1:0]  wb_data_i,
  output logic [WD-1:0]  op_o
);

  logic zero_hit;
  logic wb_hit;

  assign zero_hit = (ZERO_REG != 0) && (rs_i == '0);
  // The register file only commits at the edge, so a write landing this
  // cycle must be forwarded from the write-back port directly.
  assign wb_hit   = wb_we_i && (wb_rd_i == rs_i);

  always_comb begin
    op_o = rf_rd_i;
    if (zero_hit) begin
      op_o = '0;
    end else if (wb_hit) begin
      op_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: drives RF read addresses, bypasses write-back, registers operands+control.
// Latency: one cycle from ID inputs to ex_* outputs.
// Backpressure: holds ex_* while !ex_ready_i; id_stall_o asserts on load-use hazard or EX stall.
//   Ports: clk/reset; id_* decoded instruction; rf_ra*_o / rf_rd*_i register file read;
//   wb_* write-back port; ex_ready_i / flush_i from EX; ex_* pipeline register outputs;
//   id_stall_o hold request to ID; stall_cnt_o saturating load-use stall cycle count.
module id_ex_stage
  import my_pkg::*;
#(
  parameter int WD       = my_pkg::WD,
  parameter int SEL      = my_pkg::SEL,
  parameter int ZERO_REG = 1,
  parameter int PCNT_W   = my_pkg::PCNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid_i,
  input  logic [SEL-1:0]    id_rs1_i,
  input  logic [SEL-1:0]    id_rs2_i,
  input  logic [SEL-1:0]    id_rd_i,
  input  logic              id_we_i,
  input  logic              id_is_load_i,
  input  logic [WD-1:0]     id_imm_i,
  output logic [SEL-1:0]    rf_ra1_o,
  output logic [SEL-1:0]    rf_ra2_o,
  input  logic [WD-1:0]     rf_rd1_i,
  input  logic [WD-1:0]     rf_rd2_i,
  input  logic              wb_we_i,
  input  logic [SEL-1:0]    wb_rd_i,
  input  logic [WD-1:0]     wb_data_i,
  input  logic              ex_ready_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic [WD-1:0]     ex_op1_o,
  output logic [WD-1:0]     ex_op2_o,
  output logic [WD-1:0]     ex_imm_o,
  output logic [SEL-1:0]    ex_rd_o,
  output logic              ex_we_o,
  output logic              ex_is_load_o,
  output logic              id_stall_o,
  output logic [PCNT_W-1:0] stall_cnt_o
);

  logic [WD-1:0]     op1_sel;
  logic [WD-1:0]     op2_sel;
  logic              adv;
  logic              hazard;
  logic              rd_is_zero;

  logic              ex_valid_q, ex_valid_d;
  id_ex_t            ex_q, ex_d;
  logic [PCNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign rf_ra1_o = id_rs1_i;
  assign rf_ra2_o = id_rs2_i;

  operand_bypass #(.WD(WD), .SEL(SEL), .ZERO_REG(ZERO_REG)) u_byp_op1 (
    .rs_i      (id_rs1_i),
    .rf_rd_i   (rf_rd1_i),
    .wb_we_i   (wb_we_i),
    .wb_rd_i   (wb_rd_i),
    .wb_data_i (wb_data_i),
    .op_o      (op1_sel)
  );

  operand_bypass #(.WD(WD), .SEL(SEL), .ZERO_REG(ZERO_REG)) u_byp_op2 (
    .rs_i      (id_rs2_i),
    .rf_rd_i   (rf_rd2_i),
    .wb_we_i   (wb_we_i),
    .wb_rd_i   (wb_rd_i),
    .wb_data_i (wb_data_i),
    .op_o      (op2_sel)
  );

  assign adv        = !ex_valid_q || ex_ready_i;
  assign rd_is_zero = (ZERO_REG != 0) && (ex_q.rd == '0);

  // Load result is not available until after EX, so a dependent instruction
  // must wait one cycle behind it. The zero register is never a real dependency.
  assign hazard = id_valid_i && ex_valid_q && ex_q.is_load && ex_q.we &&
                  ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i)) && !rd_is_zero;

  assign id_stall_o = id_valid_i && (hazard || !adv);

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;

    if (flush_i) begin
      ex_valid_d = 1'b0;
      ex_d       = '0;
    end else if (adv && (hazard || !id_valid_i)) begin
      // Bubble: zeroed payload so a stale load/we can never match a hazard.
      ex_valid_d = 1'b0;
      ex_d       = '0;
    end else if (adv) begin
      ex_valid_d     = 1'b1;
      ex_d.op1       = op1_sel;
      ex_d.op2       = op2_sel;
      ex_d.imm       = id_imm_i;
      ex_d.rd        = id_rd_i;
      ex_d.we        = id_we_i;
      ex_d.is_load   = id_is_load_i;
    end

    if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_op1_o     = ex_q.op1;
  assign ex_op2_o     = ex_q.op2;
  assign ex_imm_o     = ex_q.imm;
  assign ex_rd_o      = ex_q.rd;
  assign ex_we_o      = ex_q.we;
  assign ex_is_load_o = ex_q.is_load;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a small register file array driving the read ports.
// Latency: checks ex_* one cycle after ID presentation.
// Backpressure: exercises ex_ready_i low, flush, load-use bubbles and counter saturation.
module tb_id_ex_stage;
  import my_pkg::*;

  localparam int PCNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid_i;
  logic [SEL-1:0]    id_rs1_i, id_rs2_i, id_rd_i;
  logic              id_we_i, id_is_load_i;
  logic [WD-1:0]     id_imm_i;
  logic [SEL-1:0]    rf_ra1_o, rf_ra2_o;
  logic [WD-1:0]     rf_rd1_i, rf_rd2_i;
  logic              wb_we_i;
  logic [SEL-1:0]    wb_rd_i;
  logic [WD-1:0]     wb_data_i;
  logic              ex_ready_i, flush_i;
  logic              ex_valid_o;
  logic [WD-1:0]     ex_op1_o, ex_op2_o, ex_imm_o;
  logic [SEL-1:0]    ex_rd_o;
  logic              ex_we_o, ex_is_load_o, id_stall_o;
  logic [PCNT_W-1:0] stall_cnt_o;

  logic [WD-1:0] rf_mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rf_rd1_i = rf_mem[rf_ra1_o];
  assign rf_rd2_i = rf_mem[rf_ra2_o];

  id_ex_stage #(.WD(WD), .SEL(SEL), .ZERO_REG(1), .PCNT_W(PCNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rd_i      (id_rd_i),
    .id_we_i      (id_we_i),
    .id_is_load_i (id_is_load_i),
    .id_imm_i     (id_imm_i),
    .rf_ra1_o     (rf_ra1_o),
    .rf_ra2_o     (rf_ra2_o),
    .rf_rd1_i     (rf_rd1_i),
    .rf_rd2_i     (rf_rd2_i),
    .wb_we_i      (wb_we_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .ex_ready_i   (ex_ready_i),
    .flush_i      (flush_i),
    .ex_valid_o   (ex_valid_o),
    .ex_op1_o     (ex_op1_o),
    .ex_op2_o     (ex_op2_o),
    .ex_imm_o     (ex_imm_o),
    .ex_rd_o      (ex_rd_o),
    .ex_we_o      (ex_we_o),
    .ex_is_load_o (ex_is_load_o),
    .id_stall_o   (id_stall_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [SEL-1:0] rs1, input logic [SEL-1:0] rs2,
                        input logic [SEL-1:0] rd, input logic we, input logic ld,
                        input logic [WD-1:0] imm);
    id_valid_i   = v;
    id_rs1_i     = rs1;
    id_rs2_i     = rs2;
    id_rd_i      = rd;
    id_we_i      = we;
    id_is_load_i = ld;
    id_imm_i     = imm;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
    rf_mem[0] = 32'h99;
    rf_mem[3] = 32'h11;
    rf_mem[4] = 32'h22;
    rf_mem[7] = 32'h77;

    // Reset with random activity on the inputs.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
             1'($urandom), $urandom);
      wb_we_i    = 1'($urandom);
      wb_rd_i    = 5'($urandom);
      wb_data_i  = $urandom;
      ex_ready_i = 1'($urandom);
      flush_i    = 1'($urandom);
      step();
    end
    chk("rst_valid", 64'(ex_valid_o), 64'd0);
    chk("rst_op1", 64'(ex_op1_o), 64'd0);
    chk("rst_op2", 64'(ex_op2_o), 64'd0);
    chk("rst_imm", 64'(ex_imm_o), 64'd0);
    chk("rst_rd", 64'(ex_rd_o), 64'd0);
    chk("rst_we_ld", 64'({ex_we_o, ex_is_load_o}), 64'd0);
    chk("rst_cnt", 64'(stall_cnt_o), 64'd0);

    reset      = 1'b0;
    wb_we_i    = 1'b0;
    wb_rd_i    = '0;
    wb_data_i  = '0;
    ex_ready_i = 1'b1;
    flush_i    = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    step();
    chk("idle_valid", 64'(ex_valid_o), 64'd0);

    // Plain capture from the register file.
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 32'h40);
    #1;
    chk("ra1", 64'(rf_ra1_o), 64'd3);
    chk("ra2", 64'(rf_ra2_o), 64'd4);
    chk("stall_idle", 64'(id_stall_o), 64'd0);
    step();
    chk("cap_op1", 64'(ex_op1_o), 64'h11);
    chk("cap_op2", 64'(ex_op2_o), 64'h22);
    chk("cap_imm", 64'(ex_imm_o), 64'h40);
    chk("cap_rd", 64'(ex_rd_o), 64'd5);
    chk("cap_valid", 64'(ex_valid_o), 64'd1);
    chk("cap_we", 64'(ex_we_o), 64'd1);

    // Same-cycle write-back bypass.
    wb_we_i   = 1'b1;
    wb_rd_i   = 5'd3;
    wb_data_i = 32'hDEADBEEF;
    step();
    chk("byp_op1", 64'(ex_op1_o), 64'hDEADBEEF);
    chk("byp_op2", 64'(ex_op2_o), 64'h22);

    // Zero register is never bypassed and reads as zero.
    wb_rd_i   = 5'd0;
    wb_data_i = 32'h5555;
    id_rs1_i  = 5'd0;
    step();
    chk("zero_op1", 64'(ex_op1_o), 64'd0);
    wb_we_i = 1'b0;

    // Load-use hazard: one bubble, then capture.
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h0);
    step();
    chk("ld_in_ex", 64'({ex_is_load_o, ex_rd_o}), 64'({1'b1, 5'd7}));
    set_id(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 32'h8);
    #1;
    chk("lu_stall", 64'(id_stall_o), 64'd1);
    step();
    chk("bub_valid", 64'(ex_valid_o), 64'd0);
    chk("bub_rd", 64'(ex_rd_o), 64'd0);
    chk("bub_op1", 64'(ex_op1_o), 64'd0);
    chk("bub_cnt", 64'(stall_cnt_o), 64'd1);
    chk("bub_nostall", 64'(id_stall_o), 64'd0);
    step();
    chk("after_valid", 64'(ex_valid_o), 64'd1);
    chk("after_rd", 64'(ex_rd_o), 64'd8);
    chk("after_op2", 64'(ex_op2_o), 64'h77);
    chk("after_cnt", 64'(stall_cnt_o), 64'd1);

    // Backpressure holds the register.
    ex_ready_i = 1'b0;
    set_id(1'b1, 5'd4, 5'd3, 5'd9, 1'b1, 1'b0, 32'h99);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall", 64'(id_stall_o), 64'd1);
      step();
      chk("bp_rd", 64'(ex_rd_o), 64'd8);
      chk("bp_op2", 64'(ex_op2_o), 64'h77);
      chk("bp_imm", 64'(ex_imm_o), 64'h8);
      chk("bp_valid", 64'(ex_valid_o), 64'd1);
    end

    // Flush wins over backpressure.
    flush_i = 1'b1;
    step();
    chk("fl_valid", 64'(ex_valid_o), 64'd0);
    chk("fl_rd", 64'(ex_rd_o), 64'd0);
    chk("fl_op2", 64'(ex_op2_o), 64'd0);
    flush_i = 1'b0;
    #1;
    chk("fl_nostall", 64'(id_stall_o), 64'd0);

    // Saturation: load parked in EX under backpressure, dependent in ID.
    ex_ready_i = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h0);
    step();
    ex_ready_i = 1'b0;
    set_id(1'b1, 5'd7, 5'd2, 5'd10, 1'b1, 1'b0, 32'h0);
    step();
    chk("sat_cnt2", 64'(stall_cnt_o), 64'd2);
    for (int i = 0; i < (1 << PCNT_W) + 3; i++) step();
    chk("sat_cnt", 64'(stall_cnt_o), 64'hFFFF);
    chk("sat_valid", 64'(ex_valid_o), 64'd1);

    // Asynchronous reset in the middle of the stall.
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_cnt", 64'(stall_cnt_o), 64'd0);
    chk("mrst_valid", 64'(ex_valid_o), 64'd0);
    chk("mrst_rd_ld", 64'({ex_rd_o, ex_is_load_o, ex_we_o}), 64'd0);
    chk("mrst_stall", 64'(id_stall_o), 64'd0);
    step();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
